// File: rtl/sprite_ram_wr_arb.sv
`default_nettype none
// sprite_ram_wr_arb: round-robin CPU/loader write arbiter for the sprite RAM plus sprite control registers.
// Optional macro SPRITE_ARB_SHADOW_EN: register writes go to staging and apply after frame_start.
module sprite_ram_wr_arb #(
  parameter int RGB_SIZE      = 12,
  parameter int SPRITE_RAM_AW = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic [SPRITE_RAM_AW-1:0] cpu_addr,
  input  logic [RGB_SIZE-1:0]      cpu_data,
  output logic                     cpu_ack,
  input  logic                     ld_req,
  input  logic [SPRITE_RAM_AW-1:0] ld_addr,
  input  logic [RGB_SIZE-1:0]      ld_data,
  output logic                     ld_ack,
  input  logic                     reg_we,
  input  logic [1:0]               reg_addr,
  input  logic [31:0]              reg_wdata,
  input  logic                     frame_start,
  output logic [31:0]              x0,
  output logic [31:0]              y0,
  output logic [31:0]              sprite_rate,
  output logic                     sprite_vld,
  output logic                     sprite_ram_we,
  output logic [SPRITE_RAM_AW-1:0] sprite_ram_addr_w,
  output logic [RGB_SIZE-1:0]      sprite_ram_din
);

  logic                     last_ld_q;
  logic                     last_ld_d;
  logic                     grant_cpu;
  logic                     grant_ld;
  logic                     we_q;
  logic [SPRITE_RAM_AW-1:0] addr_q;
  logic [RGB_SIZE-1:0]      din_q;
  logic [31:0]              x0_q;
  logic [31:0]              y0_q;
  logic [31:0]              rate_q;
  logic                     vld_q;

  // On contention the requester that did not win last time gets the slot.
  always_comb begin
    grant_cpu = !rst && cpu_req && (!ld_req || last_ld_q);
    grant_ld  = !rst && ld_req && !(cpu_req && last_ld_q);
    last_ld_d = last_ld_q;
    if (grant_cpu) begin
      last_ld_d = 1'b0;
    end else if (grant_ld) begin
      last_ld_d = 1'b1;
    end
  end

  assign cpu_ack = grant_cpu;
  assign ld_ack  = grant_ld;

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      last_ld_q <= 1'b1;
    end else begin
      we_q      <= grant_cpu | grant_ld;
      last_ld_q <= last_ld_d;
      if (grant_cpu) begin
        addr_q <= cpu_addr;
        din_q  <= cpu_data;
      end else if (grant_ld) begin
        addr_q <= ld_addr;
        din_q  <= ld_data;
      end
    end
  end

`ifdef SPRITE_ARB_SHADOW_EN
  logic [31:0] stg_x0_q;
  logic [31:0] stg_y0_q;
  logic [31:0] stg_rate_q;
  logic        stg_vld_q;

  // Outputs copy the staging contents as they stood before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_x0_q   <= '0;
      stg_y0_q   <= '0;
      stg_rate_q <= '0;
      stg_vld_q  <= 1'b0;
      x0_q       <= '0;
      y0_q       <= '0;
      rate_q     <= '0;
      vld_q      <= 1'b0;
    end else begin
      if (frame_start) begin
        x0_q   <= stg_x0_q;
        y0_q   <= stg_y0_q;
        rate_q <= stg_rate_q;
        vld_q  <= stg_vld_q;
      end
      if (reg_we) begin
        case (reg_addr)
          2'd0:    stg_x0_q   <= reg_wdata;
          2'd1:    stg_y0_q   <= reg_wdata;
          2'd2:    stg_rate_q <= reg_wdata;
          default: stg_vld_q  <= reg_wdata[0];
        endcase
      end
    end
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q   <= '0;
      y0_q   <= '0;
      rate_q <= '0;
      vld_q  <= 1'b0;
    end else if (reg_we) begin
      case (reg_addr)
        2'd0:    x0_q   <= reg_wdata;
        2'd1:    y0_q   <= reg_wdata;
        2'd2:    rate_q <= reg_wdata;
        default: vld_q  <= reg_wdata[0];
      endcase
    end
  end
`endif

  assign x0                = x0_q;
  assign y0                = y0_q;
  assign sprite_rate       = rate_q;
  assign sprite_vld        = vld_q;
  assign sprite_ram_we     = we_q;
  assign sprite_ram_addr_w = addr_q;
  assign sprite_ram_din    = din_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_ram_wr_arb.sv
`default_nettype none
// tb_sprite_ram_wr_arb: vector table, directed corner sequences and random traffic against a reference model.
module tb_sprite_ram_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, ld_req, cpu_ack, ld_ack;
  logic [11:0] cpu_addr, ld_addr, cpu_data, ld_data;
  logic        reg_we, frame_start;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] x0, y0, sprite_rate;
  logic        sprite_vld, sprite_ram_we;
  logic [11:0] sprite_ram_addr_w, sprite_ram_din;

  sprite_ram_wr_arb #(.RGB_SIZE(12), .SPRITE_RAM_AW(12)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .frame_start(frame_start),
    .x0(x0), .y0(y0), .sprite_rate(sprite_rate), .sprite_vld(sprite_vld),
    .sprite_ram_we(sprite_ram_we), .sprite_ram_addr_w(sprite_ram_addr_w),
    .sprite_ram_din(sprite_ram_din)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_last_was_ld = 1'b1;
  bit          m_we = 1'b0;
  logic [11:0] m_addr = '0, m_din = '0;
  logic [31:0] m_out [4] = '{default: '0};
  logic [31:0] m_stg [4] = '{default: '0};
  logic        seen_cpu_ack, seen_ld_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: check acks mid-cycle, advance the model, check registered outputs after the edge.
  task automatic cycle();
    int          winner;
    logic [31:0] w;
    @(negedge clk);
    winner = 0;
    if (!rst) begin
      if (cpu_req && ld_req) winner = m_last_was_ld ? 1 : 2;
      else if (cpu_req)      winner = 1;
      else if (ld_req)       winner = 2;
    end
    seen_cpu_ack = cpu_ack;
    seen_ld_ack  = ld_ack;
    chk("cpu_ack", {31'b0, cpu_ack}, (winner == 1) ? 32'd1 : 32'd0);
    chk("ld_ack",  {31'b0, ld_ack},  (winner == 2) ? 32'd1 : 32'd0);
    @(posedge clk);
    #1;
    if (rst) begin
      m_last_was_ld = 1'b1;
      m_we = 1'b0; m_addr = '0; m_din = '0;
      for (int i = 0; i < 4; i++) begin m_out[i] = '0; m_stg[i] = '0; end
    end else begin
      m_we = (winner != 0);
      if (winner == 1) begin m_addr = cpu_addr; m_din = cpu_data; m_last_was_ld = 1'b0; end
      if (winner == 2) begin m_addr = ld_addr;  m_din = ld_data;  m_last_was_ld = 1'b1; end
      w = (reg_addr == 2'd3) ? {31'b0, reg_wdata[0]} : reg_wdata;
`ifdef SPRITE_ARB_SHADOW_EN
      if (frame_start) for (int i = 0; i < 4; i++) m_out[i] = m_stg[i];
      if (reg_we) m_stg[reg_addr] = w;
`else
      if (reg_we) m_out[reg_addr] = w;
`endif
    end
    chk("ram_we",   {31'b0, sprite_ram_we}, {31'b0, m_we});
    chk("ram_addr", {20'b0, sprite_ram_addr_w}, {20'b0, m_addr});
    chk("ram_din",  {20'b0, sprite_ram_din}, {20'b0, m_din});
    chk("x0", x0, m_out[0]);
    chk("y0", y0, m_out[1]);
    chk("rate", sprite_rate, m_out[2]);
    chk("vld", {31'b0, sprite_vld}, m_out[3]);
  endtask

  task automatic idle_inputs();
    cpu_req = 0; ld_req = 0; reg_we = 0; frame_start = 0;
    cpu_addr = '0; cpu_data = '0; ld_addr = '0; ld_data = '0;
    reg_addr = '0; reg_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  typedef struct {
    logic        cr, lr;
    logic [11:0] ca, cd, la, ld;
    logic        eca, ela, ewe;
    logic [11:0] eaddr, edin;
  } vec_t;

  vec_t tbl [8];

  initial begin
    rst = 1;
    idle_inputs();
    tbl[0] = '{1, 1, 12'h010, 12'h111, 12'h200, 12'h222, 1, 0, 1, 12'h010, 12'h111};
    tbl[1] = '{1, 1, 12'h010, 12'h111, 12'h200, 12'h222, 0, 1, 1, 12'h200, 12'h222};
    tbl[2] = '{1, 1, 12'h010, 12'h111, 12'h200, 12'h222, 1, 0, 1, 12'h010, 12'h111};
    tbl[3] = '{1, 1, 12'h010, 12'h111, 12'h200, 12'h222, 0, 1, 1, 12'h200, 12'h222};
    tbl[4] = '{0, 0, 12'h000, 12'h000, 12'h000, 12'h000, 0, 0, 0, 12'h200, 12'h222};
    tbl[5] = '{1, 0, 12'h005, 12'hF00, 12'h000, 12'h000, 1, 0, 1, 12'h005, 12'hF00};
    tbl[6] = '{0, 1, 12'h000, 12'h000, 12'h300, 12'h333, 0, 1, 1, 12'h300, 12'h333};
    tbl[7] = '{1, 1, 12'h010, 12'h111, 12'h200, 12'h222, 1, 0, 1, 12'h010, 12'h111};

    do_reset();
    chk("reset_we", {31'b0, sprite_ram_we}, 32'd0);
    chk("reset_x0", x0, 32'd0);
    chk("reset_vld", {31'b0, sprite_vld}, 32'd0);

    // Contention from reset, idle, single requesters
    for (int i = 0; i < 8; i++) begin
      cpu_req = tbl[i].cr; ld_req = tbl[i].lr;
      cpu_addr = tbl[i].ca; cpu_data = tbl[i].cd;
      ld_addr = tbl[i].la; ld_data = tbl[i].ld;
      cycle();
      chk($sformatf("tbl%0d_cpu_ack", i), {31'b0, seen_cpu_ack}, {31'b0, tbl[i].eca});
      chk($sformatf("tbl%0d_ld_ack", i),  {31'b0, seen_ld_ack},  {31'b0, tbl[i].ela});
      chk($sformatf("tbl%0d_we", i),   {31'b0, sprite_ram_we}, {31'b0, tbl[i].ewe});
      chk($sformatf("tbl%0d_addr", i), {20'b0, sprite_ram_addr_w}, {20'b0, tbl[i].eaddr});
      chk($sformatf("tbl%0d_din", i),  {20'b0, sprite_ram_din}, {20'b0, tbl[i].edin});
    end
    idle_inputs();
    cycle();

    // Loader burst: eight back-to-back writes
    for (int i = 0; i < 8; i++) begin
      ld_req = 1; ld_addr = 12'h100 + 12'(i); ld_data = 12'(i + 1);
      cycle();
      chk("burst_we", {31'b0, sprite_ram_we}, 32'd1);
      chk("burst_addr", {20'b0, sprite_ram_addr_w}, 32'h100 + 32'(i));
    end

    // Reset in the middle of a loader stream
    ld_req = 1; ld_addr = 12'h1AA; ld_data = 12'h0BB;
    reg_we = 1; reg_addr = 2'd2; reg_wdata = 32'hDEAD_BEEF;
    cycle();
    reg_we = 0;
    rst = 1;
    cycle();
    chk("rst_ack", {31'b0, seen_ld_ack}, 32'd0);
    chk("rst_we", {31'b0, sprite_ram_we}, 32'd0);
    chk("rst_addr", {20'b0, sprite_ram_addr_w}, 32'd0);
    chk("rst_rate", sprite_rate, 32'd0);
    rst = 0;
    cpu_req = 1; cpu_addr = 12'h0C1; cpu_data = 12'h0C2;
    cycle();
    chk("post_rst_cpu_wins", {31'b0, seen_cpu_ack}, 32'd1);
    idle_inputs();
    cycle();

    // Register write timing
    do_reset();
    reg_we = 1; reg_addr = 2'd0; reg_wdata = 32'd100;
    cycle();
    reg_we = 0;
`ifdef SPRITE_ARB_SHADOW_EN
    chk("shadow_x0_hold", x0, 32'd0);
    for (int i = 0; i < 4; i++) cycle();
    chk("shadow_x0_hold2", x0, 32'd0);
    frame_start = 1;
    cycle();
    frame_start = 0;
    chk("shadow_x0_load", x0, 32'd100);
    reg_we = 1; reg_addr = 2'd1; reg_wdata = 32'd7; frame_start = 1;
    cycle();
    reg_we = 0; frame_start = 0;
    chk("coinc_y0_unchanged", y0, 32'd0);
    cycle();
    chk("coinc_y0_still", y0, 32'd0);
    frame_start = 1;
    cycle();
    frame_start = 0;
    chk("coinc_y0_next", y0, 32'd7);
`else
    chk("direct_x0", x0, 32'd100);
    reg_we = 1; reg_addr = 2'd3; reg_wdata = 32'hFFFF_FFFE; frame_start = 1;
    cycle();
    chk("direct_vld_bit0", {31'b0, sprite_vld}, 32'd0);
    reg_wdata = 32'h0000_0003;
    cycle();
    reg_we = 0; frame_start = 0;
    chk("direct_vld_set", {31'b0, sprite_vld}, 32'd1);
`endif

    // Random traffic; requests are held until acknowledged
    idle_inputs();
    seen_cpu_ack = 0; seen_ld_ack = 0;
    for (int n = 0; n < 600; n++) begin
      if (!(cpu_req && !seen_cpu_ack && !rst)) begin
        cpu_req = ($urandom_range(0, 2) != 0); cpu_addr = 12'($urandom); cpu_data = 12'($urandom);
      end
      if (!(ld_req && !seen_ld_ack && !rst)) begin
        ld_req = ($urandom_range(0, 2) != 0); ld_addr = 12'($urandom); ld_data = 12'($urandom);
      end
      reg_we      = ($urandom_range(0, 3) == 0);
      reg_addr    = 2'($urandom);
      reg_wdata   = $urandom;
      frame_start = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
